nexus_micro_ingress_arb: RTL and testbench
==========================================

Name: nexus_micro_ingress_arb

Overview:
- Front-end stage directly upstream of the 16-entry micro sort-and-shift register.
- Buffers incoming push traffic in a small FIFO with valid/ready backpressure.
- Accepts dequeue requests from the scheduler.
- Issues at most one push or one pop to the sorter per cycle, so the sorter never sees both.
- Default arbitration favours pops; a starvation counter guarantees push progress.

Parameters:
- PTW, 16, priority width; priority sits in bits [PTW-1:0] of each entry, lower value = higher priority.
- MTW, 32, metadata width; entry width is MTW+PTW.
- FIFO_DEPTH, 4, ingress FIFO entries; power of two, minimum 2.
- STARVE_LIMIT, 8, consecutive lost push arbitrations before push is forced; range 1..255.

Ports:
- i_clk, input, 1: clock.
- i_arst_n, input, 1: reset, synchronous and active-low (sampled on the i_clk rising edge only).
- i_in_valid, input, 1: upstream entry valid.
- o_in_ready, output, 1: ingress FIFO can accept.
- i_in_data, input, MTW+PTW: upstream entry.
- i_deq_req, input, 1: scheduler wants one element this cycle (level; each cycle it is granted consumes one element).
- o_deq_valid, output, 1: one-cycle pulse, o_deq_data valid.
- o_deq_data, output, MTW+PTW: dequeued entry, registered.
- o_deq_grant, output, 1: combinational; pop issued to sorter this cycle.
- o_srt_push, output, 1: push strobe to sorter.
- o_srt_push_data, output, MTW+PTW: FIFO head.
- o_srt_pop, output, 1: pop strobe to sorter.
- i_srt_pop_data, input, MTW+PTW: sorter head entry (combinational).
- i_srt_full, input, 1: sorter full.
- i_srt_empty, input, 1: sorter empty.
- o_fifo_count, output, $clog2(FIFO_DEPTH+1): FIFO occupancy.

Behaviour:
- Reset (i_arst_n=0 at a clock edge):
  - FIFO pointers and count cleared to 0; starvation counter cleared to 0.
  - o_deq_valid=0 and o_deq_data=0.
  - o_srt_push=0 and o_srt_pop=0 from the first post-reset cycle.
  - o_in_ready=1 in the first cycle after reset is released.
  - A reset mid-operation flushes buffered entries without draining them. The sorter shares the same reset.
- Ingress:
  - o_in_ready = (count != FIFO_DEPTH). It does not depend on a same-cycle read.
  - Write occurs when i_in_valid & o_in_ready.
  - Simultaneous write and sorter-push read in the same cycle is legal: count is unchanged and pointers wrap modulo FIFO_DEPTH.
- Candidates, evaluated each cycle:
  - push_c = (count != 0) & !i_srt_full.
  - pop_c = i_deq_req & !i_srt_empty.
- Grant:
  - If pop_c & push_c & (starve_cnt == STARVE_LIMIT): push wins.
  - Else if pop_c: pop wins.
  - Else if push_c: push wins.
  - Else: idle.
  - o_srt_push and o_srt_pop are never both 1.
- Starvation counter (8 bits):
  - Increments when push_c=1 and pop is granted.
  - Clears when push is granted or push_c=0.
  - Saturates at STARVE_LIMIT.
- Push path: o_srt_push_data = FIFO head (combinational from storage). When a push is granted, the FIFO read pointer advances at the same edge.
- Pop path:
  - o_srt_pop = o_deq_grant.
  - At that edge, o_deq_data <= i_srt_pop_data, and o_deq_valid=1 for exactly the next cycle.
  - Latency is 1 cycle from grant to o_deq_valid.
  - o_deq_data holds its value until the next pop.
- Empty sorter with FIFO data and i_deq_req=1:
  - The push is granted first.
  - The pop is eligible in the following cycle once i_srt_empty falls.
  - A request is never satisfied directly from the FIFO, which preserves sorted order.
- Full sorter: push_c=0 and entries accumulate in the FIFO. When the FIFO is also full, o_in_ready=0.
- No data is ever dropped, and no pop is issued while i_srt_empty=1.

Test Plan:
- Reset then 3 pushes (prio 30, 10, 20) with i_deq_req=0:
  - Pushes reach the sorter on 3 consecutive cycles, each one cycle after its FIFO write.
  - o_fifo_count returns to 0.
  - Three subsequent pops return prio 10, 20, 30, with o_deq_valid one cycle after each o_deq_grant.
- Sorter mock full (i_srt_full=1) with 5 upstream beats at FIFO_DEPTH=4:
  - 4 beats accepted, then o_in_ready=0 and o_fifo_count=4.
  - After i_srt_full falls, the FIFO drains 1 per cycle and ready returns.
- Continuous i_deq_req=1 with non-empty sorter and FIFO non-empty, STARVE_LIMIT=8:
  - 8 consecutive pops, then 1 push on the 9th cycle, then the pattern repeats.
  - Push and pop are never asserted together.
- i_deq_req=1 with sorter empty and FIFO holding prio 5:
  - Cycle 0: push. Cycle 1: pop. Cycle 2: o_deq_valid=1 with prio 5.
- Write and read in the same cycle at count=4: the write is refused because o_in_ready=0. At count=2, count stays at 2 and pointer wrap is correct across 8 iterations.
- Assert i_arst_n=0 for 1 cycle with 3 FIFO entries and o_deq_valid pending:
  - Next cycle o_fifo_count=0, o_deq_valid=0, o_srt_push=0 and o_srt_pop=0.
  - o_in_ready=1 after release.

Source files
------------

// File: rtl/nexus_micro_ingress_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : nexus_micro_ingress_arb_if
//  Brief    : Upstream, scheduler and sorter signals of the ingress arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface nexus_micro_ingress_arb_if #(
    parameter int PTW        = 16,
    parameter int MTW        = 32,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_w  = MTW + PTW;
    localparam int c_cw = $clog2(FIFO_DEPTH + 1);

    logic             i_in_valid;
    logic             o_in_ready;
    logic [c_w-1:0]   i_in_data;
    logic             i_deq_req;
    logic             o_deq_valid;
    logic [c_w-1:0]   o_deq_data;
    logic             o_deq_grant;
    logic             o_srt_push;
    logic [c_w-1:0]   o_srt_push_data;
    logic             o_srt_pop;
    logic [c_w-1:0]   i_srt_pop_data;
    logic             i_srt_full;
    logic             i_srt_empty;
    logic [c_cw-1:0]  o_fifo_count;

    modport slave (
        input  i_in_valid, i_in_data, i_deq_req, i_srt_pop_data, i_srt_full, i_srt_empty,
        output o_in_ready, o_deq_valid, o_deq_data, o_deq_grant,
               o_srt_push, o_srt_push_data, o_srt_pop, o_fifo_count
    );

    modport master (
        output i_in_valid, i_in_data, i_deq_req, i_srt_pop_data, i_srt_full, i_srt_empty,
        input  o_in_ready, o_deq_valid, o_deq_data, o_deq_grant,
               o_srt_push, o_srt_push_data, o_srt_pop, o_fifo_count
    );
endinterface
`default_nettype wire

// File: rtl/nexus_micro_ingress_arb.sv
`default_nettype none
// ============================================================================
//  Module   : nexus_micro_ingress_arb
//  Brief    : Ingress FIFO plus push/pop arbiter in front of the micro sorter;
//             pops win by default, a starvation counter forces push progress.
//  Revision : 1.0 - initial release
// ============================================================================
module nexus_micro_ingress_arb #(
    parameter int PTW          = 16,
    parameter int MTW          = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     i_clk,
    input  logic                     i_arst_n,
    nexus_micro_ingress_arb_if.slave bus
);
    localparam int            c_w     = MTW + PTW;
    localparam int            c_aw    = $clog2(FIFO_DEPTH);
    localparam int            c_cw    = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_cw-1:0] c_depth = c_cw'(FIFO_DEPTH);
    localparam logic [7:0]    c_limit = 8'(STARVE_LIMIT);

    logic [c_w-1:0]  r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic [7:0]      r_starve;
    logic            r_deq_valid;
    logic [c_w-1:0]  r_deq_data;

    logic w_in_ready;
    logic w_wr;
    logic w_push_c;
    logic w_pop_c;
    logic w_force_push;
    logic w_grant_push;
    logic w_grant_pop;

    assign w_in_ready   = (r_count != c_depth);
    assign w_wr         = bus.i_in_valid & w_in_ready;

    // Grants are held off while reset is asserted so nothing reaches the sorter
    assign w_push_c     = i_arst_n & (r_count != '0) & ~bus.i_srt_full;
    assign w_pop_c      = i_arst_n & bus.i_deq_req & ~bus.i_srt_empty;
    assign w_force_push = (r_starve == c_limit);

    assign w_grant_push = w_push_c & (~w_pop_c | w_force_push);
    assign w_grant_pop  = w_pop_c & ~(w_push_c & w_force_push);

    // Storage carries no reset; occupancy alone decides what is valid
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= bus.i_in_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_arst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_starve    <= '0;
            r_deq_valid <= 1'b0;
            r_deq_data  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_grant_push) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_wr, w_grant_push})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase

            if (w_grant_push || !w_push_c) begin
                r_starve <= '0;
            end else if (w_grant_pop && (r_starve != c_limit)) begin
                r_starve <= r_starve + 8'd1;
            end

            r_deq_valid <= w_grant_pop;
            if (w_grant_pop) begin
                r_deq_data <= bus.i_srt_pop_data;
            end
        end
    end

    assign bus.o_in_ready      = w_in_ready;
    assign bus.o_fifo_count    = r_count;
    assign bus.o_srt_push      = w_grant_push;
    assign bus.o_srt_push_data = r_mem[r_rd_ptr];
    assign bus.o_srt_pop       = w_grant_pop;
    assign bus.o_deq_grant     = w_grant_pop;
    assign bus.o_deq_valid     = r_deq_valid;
    assign bus.o_deq_data      = r_deq_data;
endmodule
`default_nettype wire

// File: tb/tb_nexus_micro_ingress_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nexus_micro_ingress_arb
//  Brief    : Directed bench with a behavioural 16-entry sorter and queues
//             of expected push data and dequeue data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nexus_micro_ingress_arb;
    localparam int PTW = 16;
    localparam int MTW = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int W = MTW + PTW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic force_full = 1'b0;
    always #5 clk = ~clk;

    nexus_micro_ingress_arb_if #(.PTW(PTW), .MTW(MTW), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

    nexus_micro_ingress_arb #(
        .PTW(PTW), .MTW(MTW), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .i_clk   (clk),
        .i_arst_n(rst_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_push [$];
    logic [W-1:0] exp_deq  [$];

    // Behavioural sorter: ascending priority, stable for equal priorities
    logic [W-1:0] srt_mem [16];
    int           srt_cnt = 0;

    always @(posedge clk) begin : mock_sorter
        logic [W-1:0] t [16];
        int n;
        int pos;
        t = srt_mem;
        n = srt_cnt;
        if (!rst_n) begin
            n = 0;
        end else if (bus.o_srt_push && n < 16) begin
            pos = n;
            for (int k = 0; k < 16; k++)
                if (k < n && pos == n && bus.o_srt_push_data[PTW-1:0] < t[k][PTW-1:0]) pos = k;
            for (int k = 15; k > 0; k--)
                if (k > pos) t[k] = t[k-1];
            t[pos] = bus.o_srt_push_data;
            n = n + 1;
        end else if (bus.o_srt_pop && n > 0) begin
            for (int k = 0; k < 15; k++) t[k] = t[k+1];
            n = n - 1;
        end
        srt_mem <= t;
        srt_cnt <= n;
    end

    assign bus.i_srt_pop_data = srt_mem[0];
    assign bus.i_srt_full     = force_full || (srt_cnt == 16);
    assign bus.i_srt_empty    = (srt_cnt == 0);

    function automatic logic [W-1:0] mk(input int p);
        return {32'(32'hA500_0000 + p), 16'(p)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a push or a dequeue
    initial forever begin
        @(negedge clk);
        if (bus.o_srt_push) begin
            if (exp_push.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL push_unexpected: actual=%0h required=none", bus.o_srt_push_data);
            end else begin
                chk("push_data", bus.o_srt_push_data, exp_push.pop_front());
            end
        end
        if (bus.o_deq_valid) begin
            if (exp_deq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL deq_unexpected: actual=%0h required=none", bus.o_deq_data);
            end else begin
                chk("deq_data", bus.o_deq_data, exp_deq.pop_front());
            end
        end
        if (bus.o_srt_push || bus.o_srt_pop)
            chk("push_pop_exclusive", bus.o_srt_push & bus.o_srt_pop, 0);
        if (bus.o_deq_grant || bus.o_srt_pop)
            chk("pop_eq_grant", bus.o_srt_pop, bus.o_deq_grant);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int t1p [3] = '{30, 10, 20};
    int t1c [5] = '{0, 1, 1, 1, 0};
    int k;

    initial begin
        bus.i_in_valid = 1'b0;
        bus.i_in_data  = '0;
        bus.i_deq_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_count", bus.o_fifo_count, 0);
        chk("rst_ready", bus.o_in_ready, 1);
        chk("rst_deq_valid", bus.o_deq_valid, 0);
        chk("rst_deq_data", bus.o_deq_data, 0);
        chk("rst_push", bus.o_srt_push, 0);
        chk("rst_pop", bus.o_srt_pop, 0);
        tick();

        // Three writes reach the sorter one cycle after each write
        for (int c = 0; c < 5; c++) begin
            bus.i_in_valid = (c < 3);
            if (c < 3) bus.i_in_data = mk(t1p[c]);
            @(negedge clk);
            if (c < 3) begin
                chk("t1_ready", bus.o_in_ready, 1);
                exp_push.push_back(mk(t1p[c]));
            end
            chk("t1_push", bus.o_srt_push, (c >= 1 && c <= 3));
            chk("t1_count", bus.o_fifo_count, t1c[c]);
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            bus.i_deq_req = (c < 3);
            if (c < 3) exp_deq.push_back(mk(c == 0 ? 10 : (c == 1 ? 20 : 30)));
            @(negedge clk);
            chk("t1_grant", bus.o_deq_grant, (c < 3));
            chk("t1_deq_valid", bus.o_deq_valid, (c >= 1 && c <= 3));
            if (c == 4) chk("t1_deq_hold", bus.o_deq_data, mk(30));
            tick();
        end

        // Sorter full: FIFO fills to depth, then drains once full drops
        force_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = mk(100 + c);
            @(negedge clk);
            chk("t2_ready", bus.o_in_ready, (c < 4));
            chk("t2_count", bus.o_fifo_count, c);
            if (c < 4) exp_push.push_back(mk(100 + c));
            tick();
        end
        force_full = 1'b0;
        @(negedge clk);
        chk("t2_full_ready", bus.o_in_ready, 0);
        chk("t2_full_count", bus.o_fifo_count, 4);
        chk("t2_drain_push", bus.o_srt_push, 1);
        tick();
        @(negedge clk);
        chk("t2_ready_back", bus.o_in_ready, 1);
        chk("t2_count_3", bus.o_fifo_count, 3);
        exp_push.push_back(mk(104));
        tick();
        bus.i_in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t2_drain_count", bus.o_fifo_count, 3 - c);
            chk("t2_drain_push1", bus.o_srt_push, (c < 3));
            tick();
        end

        // Preload sorter to 15 entries, then FIFO to 4 while sorter is held full
        for (int c = 0; c < 12; c++) begin
            bus.i_in_valid = (c < 10);
            bus.i_in_data  = mk(105 + c);
            @(negedge clk);
            if (c < 10) begin
                chk("t3_pre_ready", bus.o_in_ready, 1);
                exp_push.push_back(mk(105 + c));
            end
            tick();
        end
        force_full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = mk(200 + c);
            @(negedge clk);
            chk("t3_fill_ready", bus.o_in_ready, 1);
            exp_push.push_back(mk(200 + c));
            tick();
        end
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        chk("t3_fill_count", bus.o_fifo_count, 4);
        tick();

        // Continuous requests: 8 pops then a forced push, twice
        force_full    = 1'b0;
        bus.i_deq_req = 1'b1;
        k = 0;
        for (int c = 0; c < 18; c++) begin
            if (!(c == 8 || c == 17)) begin
                exp_deq.push_back(k < 15 ? mk(100 + k) : mk(200));
                k++;
            end
            @(negedge clk);
            chk("t3_push", bus.o_srt_push, (c == 8 || c == 17));
            chk("t3_grant", bus.o_deq_grant, !(c == 8 || c == 17));
            tick();
        end
        bus.i_deq_req = 1'b0;
        repeat (3) tick();
        bus.i_deq_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            exp_deq.push_back(mk(201 + c));
            @(negedge clk);
            chk("t3_tail_grant", bus.o_deq_grant, 1);
            tick();
        end
        bus.i_deq_req = 1'b0;
        repeat (2) tick();

        // Empty sorter: push first, pop next cycle, data one cycle later
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = mk(5);
        bus.i_deq_req  = 1'b1;
        exp_push.push_back(mk(5));
        @(negedge clk);
        chk("t4_w_push", bus.o_srt_push, 0);
        chk("t4_w_grant", bus.o_deq_grant, 0);
        tick();
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        chk("t4_c0_push", bus.o_srt_push, 1);
        chk("t4_c0_grant", bus.o_deq_grant, 0);
        tick();
        exp_deq.push_back(mk(5));
        @(negedge clk);
        chk("t4_c1_push", bus.o_srt_push, 0);
        chk("t4_c1_grant", bus.o_deq_grant, 1);
        tick();
        bus.i_deq_req = 1'b0;
        @(negedge clk);
        chk("t4_c2_valid", bus.o_deq_valid, 1);
        tick();

        // Write refused at count=4; count holds at 2 with write+read, pointers wrap
        force_full = 1'b1;
        for (int c = 0; c < 4; c++) begin
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = mk(300 + c);
            @(negedge clk);
            chk("t5_fill_ready", bus.o_in_ready, 1);
            exp_push.push_back(mk(300 + c));
            tick();
        end
        bus.i_in_data = mk(304);
        force_full    = 1'b0;
        @(negedge clk);
        chk("t5_refuse_ready", bus.o_in_ready, 0);
        chk("t5_refuse_count", bus.o_fifo_count, 4);
        tick();
        bus.i_in_valid = 1'b0;
        @(negedge clk);
        chk("t5_after_refuse", bus.o_fifo_count, 3);
        tick();
        for (int c = 0; c < 8; c++) begin
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = mk(310 + c);
            @(negedge clk);
            chk("t5_hold_count", bus.o_fifo_count, 2);
            chk("t5_hold_ready", bus.o_in_ready, 1);
            exp_push.push_back(mk(310 + c));
            tick();
        end
        bus.i_in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t5_tail_count", bus.o_fifo_count, 2 - c);
            tick();
        end
        bus.i_deq_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            exp_deq.push_back(c < 4 ? mk(300 + c) : mk(306 + c));
            @(negedge clk);
            chk("t5_drain_grant", bus.o_deq_grant, 1);
            tick();
        end
        bus.i_deq_req = 1'b0;
        repeat (2) tick();

        // Reset mid-operation flushes FIFO and pending dequeue
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = mk(400);
        exp_push.push_back(mk(400));
        @(negedge clk);
        chk("t6_ready", bus.o_in_ready, 1);
        tick();
        bus.i_in_valid = 1'b0;
        tick();
        force_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            bus.i_in_valid = 1'b1;
            bus.i_in_data  = mk(401 + c);
            tick();
        end
        bus.i_in_valid = 1'b0;
        bus.i_deq_req  = 1'b1;
        exp_deq.push_back(mk(400));
        @(negedge clk);
        chk("t6_count3", bus.o_fifo_count, 3);
        chk("t6_grant", bus.o_deq_grant, 1);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_pending_valid", bus.o_deq_valid, 1);
        tick();
        rst_n      = 1'b1;
        force_full = 1'b0;
        @(negedge clk);
        chk("t6_count", bus.o_fifo_count, 0);
        chk("t6_deq_valid", bus.o_deq_valid, 0);
        chk("t6_deq_data", bus.o_deq_data, 0);
        chk("t6_push", bus.o_srt_push, 0);
        chk("t6_pop", bus.o_srt_pop, 0);
        chk("t6_ready_after", bus.o_in_ready, 1);
        tick();
        bus.i_deq_req = 1'b0;
        repeat (2) tick();

        chk("push_queue_drained", exp_push.size(), 0);
        chk("deq_queue_drained", exp_deq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
